// File: rtl/checksum_engine_if.sv
// Stream-in / result-out bundle for checksum_engine.
// The engine uses the slave modport; the stream source and result consumer use master.
interface checksum_engine_if #(
  parameter int unsigned DW      = 8,
  parameter int unsigned MAX_LEN = 16
);
  localparam int unsigned CW = $clog2(MAX_LEN + 1);

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic [DW-1:0] run_sum;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] check_sum;
  logic [CW-1:0] out_len;
  logic          out_err;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, run_sum, out_valid, check_sum, out_len, out_err
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, run_sum, out_valid, check_sum, out_len, out_err
  );
endinterface

// File: rtl/checksum_engine.sv
// Frame checksum engine: accumulates beats until in_last or MAX_LEN,
// then holds one result per frame until the consumer takes it.
module checksum_engine #(
  parameter int unsigned DW      = 8,
  parameter int unsigned MAX_LEN = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             clr,
  input  logic [1:0]       mode,
  checksum_engine_if.slave bus
);
  localparam int unsigned CW = $clog2(MAX_LEN + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    mode_q, mode_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] check_sum_q, check_sum_d;
  logic [CW-1:0] out_len_q, out_len_d;
  logic          out_err_q, out_err_d;

  logic          accept;
  logic          close;
  logic          err_nx;
  logic [1:0]    mode_nx;
  logic [DW-1:0] acc_nx;
  logic [CW-1:0] cnt_nx;

  function automatic logic [DW-1:0] acc_fn(input logic [DW-1:0] a,
                                           input logic [DW-1:0] d,
                                           input logic [1:0]    m);
    logic [DW:0] s;
    s = {1'b0, a} + {1'b0, d};
    case (m)
      2'b01:   acc_fn = a ^ d;
      // end-around carry; a+d <= 2^(DW+1)-2 so the fold cannot carry again
      2'b10:   acc_fn = s[DW-1:0] + {{(DW-1){1'b0}}, s[DW]};
      default: acc_fn = s[DW-1:0];
    endcase
  endfunction

  assign accept = bus.in_valid && (state_q != S_DONE);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    out_valid_d = out_valid_q;
    check_sum_d = check_sum_q;
    out_len_d   = out_len_q;
    out_err_d   = out_err_q;
    close       = 1'b0;
    err_nx      = 1'b0;
    mode_nx     = mode_q;
    acc_nx      = acc_q;
    cnt_nx      = cnt_q;

    if (clr) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
      cnt_d       = '0;
      acc_d       = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            mode_nx = mode;
            acc_nx  = bus.in_data;
            cnt_nx  = CW'(1);
            close   = bus.in_last;
          end
        end
        S_ACC: begin
          if (accept) begin
            acc_nx = acc_fn(acc_q, bus.in_data, mode_q);
            cnt_nx = cnt_q + CW'(1);
            close  = bus.in_last || (cnt_nx == CW'(MAX_LEN));
            err_nx = !bus.in_last;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_d = 1'b0;
            state_d     = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase

      if (accept) begin
        mode_d  = mode_nx;
        acc_d   = acc_nx;
        cnt_d   = cnt_nx;
        state_d = close ? S_DONE : S_ACC;
      end

      if (close) begin
        out_valid_d = 1'b1;
        check_sum_d = (mode_nx == 2'b11) ? -acc_nx : acc_nx;
        out_len_d   = cnt_nx;
        out_err_d   = err_nx;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      mode_q      <= '0;
      out_valid_q <= 1'b0;
      check_sum_q <= '0;
      out_len_q   <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      check_sum_q <= check_sum_d;
      out_len_q   <= out_len_d;
      out_err_q   <= out_err_d;
    end
  end

  assign bus.in_ready  = (state_q != S_DONE);
  assign bus.run_sum   = acc_q;
  assign bus.out_valid = out_valid_q;
  assign bus.check_sum = check_sum_q;
  assign bus.out_len   = out_len_q;
  assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_checksum_engine.sv
// Bench for checksum_engine: directed scenarios plus randomized frames
// compared against a frame-level arithmetic model.
module tb_checksum_engine;
  localparam int unsigned DW      = 8;
  localparam int unsigned MAX_LEN = 16;
  localparam int unsigned CW      = 5;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [7:0]    cs;
    logic [CW-1:0] len;
    logic          err;
  } res_t;

  logic       clk  = 1'b0;
  logic       nrst = 1'b0;
  logic       clr  = 1'b0;
  logic [1:0] mode = 2'b00;
  int         n_cmp  = 0;
  int         n_fail = 0;
  bit         rnd_rdy = 1'b0;
  res_t       got_q[$];

  checksum_engine_if #(.DW(DW), .MAX_LEN(MAX_LEN)) bus ();

  checksum_engine #(.DW(DW), .MAX_LEN(MAX_LEN)) dut (
    .clk  (clk),
    .nrst (nrst),
    .clr  (clr),
    .mode (mode),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Record every result at the point the consumer takes it
  always @(negedge clk)
    if (bus.out_valid && bus.out_ready)
      got_q.push_back({bus.check_sum, bus.out_len, bus.out_err});

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, wanted completion");
    $fatal(1);
  end

  function automatic logic [7:0] model_cs(input logic [1:0] m, input bq_t q);
    int t;
    t = 0;
    case (m)
      2'b01: foreach (q[i]) t = t ^ int'(q[i]);
      2'b10: begin
        t = int'(q[0]);
        for (int i = 1; i < q.size(); i++) begin
          t += int'(q[i]);
          if (t > 255) t -= 255;
        end
      end
      default: begin
        foreach (q[i]) t += int'(q[i]);
        t = t % 256;
        if (m == 2'b11) t = (256 - t) % 256;
      end
    endcase
    return t[7:0];
  endfunction

  task automatic step_ready();
    if (rnd_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Present one beat and hold it until accepted; returns at accept edge + 1
  task automatic send_beat(input logic [7:0] d, input logic last);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
      step_ready();
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (!ok) begin
      n_fail++;
      $display("FAIL beat_accept: in_ready stayed 0 for 50 cycles, wanted 1");
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      step_ready();
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    #12;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.run_sum !== 8'h00) begin n_fail++; $display("FAIL rst_run_sum: got %h want 00", bus.run_sum); end
    n_cmp++; if (bus.check_sum !== 8'h00) begin n_fail++; $display("FAIL rst_check_sum: got %h want 00", bus.check_sum); end
    n_cmp++; if (bus.out_len !== 5'd0) begin n_fail++; $display("FAIL rst_out_len: got %0d want 0", bus.out_len); end
    n_cmp++; if (bus.out_err !== 1'b0) begin n_fail++; $display("FAIL rst_out_err: got %b want 0", bus.out_err); end
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_modes();
    logic [1:0] mlist [3];
    logic [7:0] cs_exp[3];
    logic [7:0] rs_exp[3];
    mlist  = '{2'd0, 2'd1, 2'd3};
    cs_exp = '{8'h78, 8'h00, 8'h88};
    rs_exp = '{8'h78, 8'h00, 8'h78};
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      mode = mlist[k];
      for (int i = 1; i <= 15; i++) send_beat(8'(i), i == 15);
      n_cmp++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL m%0d_latency: out_valid got %b want 1", mlist[k], bus.out_valid); end
      n_cmp++; if (bus.check_sum !== cs_exp[k]) begin n_fail++; $display("FAIL m%0d_cs: got %h want %h", mlist[k], bus.check_sum, cs_exp[k]); end
      n_cmp++; if (bus.run_sum !== rs_exp[k]) begin n_fail++; $display("FAIL m%0d_run_sum: got %h want %h", mlist[k], bus.run_sum, rs_exp[k]); end
      n_cmp++; if (bus.out_len !== 5'd15) begin n_fail++; $display("FAIL m%0d_len: got %0d want 15", mlist[k], bus.out_len); end
      n_cmp++; if (bus.out_err !== 1'b0) begin n_fail++; $display("FAIL m%0d_err: got %b want 0", mlist[k], bus.out_err); end
      idle(1);
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL m%0d_pulse: out_valid got %b want 0", mlist[k], bus.out_valid); end
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL m%0d_bubble: in_ready got %b want 1", mlist[k], bus.in_ready); end
    end
    mode = 2'b10;
    send_beat(8'hFF, 1'b0);
    send_beat(8'h02, 1'b1);
    n_cmp++; if (bus.check_sum !== 8'h02) begin n_fail++; $display("FAIL m2_cs: got %h want 02", bus.check_sum); end
    n_cmp++; if (bus.out_len !== 5'd2) begin n_fail++; $display("FAIL m2_len: got %0d want 2", bus.out_len); end
    idle(1);
  endtask

  task automatic test_max_len();
    mode = 2'b00;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      send_beat(8'h01, i == 19);
      if (i == 15) begin
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL max_valid: got %b want 1", bus.out_valid); end
        n_cmp++; if (bus.check_sum !== 8'h10) begin n_fail++; $display("FAIL max_cs: got %h want 10", bus.check_sum); end
        n_cmp++; if (bus.out_len !== 5'd16) begin n_fail++; $display("FAIL max_len: got %0d want 16", bus.out_len); end
        n_cmp++; if (bus.out_err !== 1'b1) begin n_fail++; $display("FAIL max_err: got %b want 1", bus.out_err); end
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL max_in_ready: got %b want 0", bus.in_ready); end
      end
    end
    n_cmp++; if (bus.check_sum !== 8'h04) begin n_fail++; $display("FAIL tail_cs: got %h want 04", bus.check_sum); end
    n_cmp++; if (bus.out_len !== 5'd4) begin n_fail++; $display("FAIL tail_len: got %0d want 4", bus.out_len); end
    n_cmp++; if (bus.out_err !== 1'b0) begin n_fail++; $display("FAIL tail_err: got %b want 0", bus.out_err); end
    idle(1);
  endtask

  task automatic test_backpressure();
    mode = 2'b00;
    bus.out_ready = 1'b0;
    send_beat(8'h10, 1'b0);
    send_beat(8'h20, 1'b0);
    send_beat(8'h30, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h05;
    bus.in_last  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", c, bus.out_valid); end
      n_cmp++; if (bus.check_sum !== 8'h60) begin n_fail++; $display("FAIL bp_hold_cs[%0d]: got %h want 60", c, bus.check_sum); end
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b want 0", c, bus.in_ready); end
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_pre_hs: out_valid got %b want 1", bus.out_valid); end
    @(posedge clk);
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_post_hs: out_valid got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_bubble: in_ready got %b want 1", bus.in_ready); end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_next_valid: got %b want 1", bus.out_valid); end
    n_cmp++; if (bus.check_sum !== 8'h05) begin n_fail++; $display("FAIL bp_next_cs: got %h want 05", bus.check_sum); end
    n_cmp++; if (bus.out_len !== 5'd1) begin n_fail++; $display("FAIL bp_next_len: got %0d want 1", bus.out_len); end
    idle(1);
  endtask

  task automatic test_back_to_back();
    bq_t  fa, fb;
    res_t ea, eb, g;
    fa = '{8'h11, 8'h22, 8'h33};
    fb = '{8'h0F, 8'hF0, 8'h5A};
    ea = {model_cs(2'b00, fa), 5'd3, 1'b0};
    eb = {model_cs(2'b01, fb), 5'd3, 1'b0};
    got_q.delete();
    bus.out_ready = 1'b1;
    mode = 2'b00;
    send_beat(fa[0], 1'b0);
    mode = 2'b01;
    send_beat(fa[1], 1'b0);
    send_beat(fa[2], 1'b1);
    foreach (fb[i]) send_beat(fb[i], i == 2);
    idle(2);
    n_cmp++; if (got_q.size() != 2) begin n_fail++; $display("FAIL b2b_count: got %0d want 2", got_q.size()); end
    if (got_q.size() >= 2) begin
      g = got_q[0];
      n_cmp++; if (g !== ea) begin n_fail++; $display("FAIL b2b_first: got %h want %h", g, ea); end
      g = got_q[1];
      n_cmp++; if (g !== eb) begin n_fail++; $display("FAIL b2b_second: got %h want %h", g, eb); end
    end
  endtask

  task automatic test_abort();
    got_q.delete();
    bus.out_ready = 1'b1;
    mode = 2'b00;
    for (int i = 1; i <= 5; i++) send_beat(8'(i * 3), 1'b0);
    #2;
    nrst = 1'b0;
    #1;
    n_cmp++; if (bus.run_sum !== 8'h00) begin n_fail++; $display("FAIL nrst_run_sum: got %h want 00", bus.run_sum); end
    n_cmp++; if (bus.check_sum !== 8'h00) begin n_fail++; $display("FAIL nrst_cs: got %h want 00", bus.check_sum); end
    n_cmp++; if (bus.out_len !== 5'd0) begin n_fail++; $display("FAIL nrst_len: got %0d want 0", bus.out_len); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL nrst_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL nrst_in_ready: got %b want 1", bus.in_ready); end
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk);
    #1;
    send_beat(8'h01, 1'b0);
    send_beat(8'h02, 1'b0);
    send_beat(8'h03, 1'b1);
    n_cmp++; if (bus.check_sum !== 8'h06) begin n_fail++; $display("FAIL nrst_next_cs: got %h want 06", bus.check_sum); end
    n_cmp++; if (bus.out_len !== 5'd3) begin n_fail++; $display("FAIL nrst_next_len: got %0d want 3", bus.out_len); end
    idle(1);
    for (int i = 0; i < 5; i++) send_beat(8'h40, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h77;
    bus.in_last  = 1'b1;
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    n_cmp++; if (bus.run_sum !== 8'h00) begin n_fail++; $display("FAIL clr_run_sum: got %h want 00", bus.run_sum); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL clr_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL clr_in_ready: got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.check_sum !== 8'h06) begin n_fail++; $display("FAIL clr_cs_held: got %h want 06", bus.check_sum); end
    n_cmp++; if (bus.out_len !== 5'd3) begin n_fail++; $display("FAIL clr_len_held: got %0d want 3", bus.out_len); end
    send_beat(8'h04, 1'b0);
    send_beat(8'h04, 1'b1);
    n_cmp++; if (bus.check_sum !== 8'h08) begin n_fail++; $display("FAIL clr_next_cs: got %h want 08", bus.check_sum); end
    n_cmp++; if (bus.out_len !== 5'd2) begin n_fail++; $display("FAIL clr_next_len: got %0d want 2", bus.out_len); end
    idle(1);
    n_cmp++; if (got_q.size() != 2) begin n_fail++; $display("FAIL abort_results: got %0d want 2", got_q.size()); end
  endtask

  task automatic test_random();
    logic [7:0] sd[$];
    logic [1:0] sm[$];
    bit         sl[$];
    bq_t        fr;
    logic [1:0] fm;
    res_t       e, g;
    res_t       exp_q[$];
    int         len;
    int         waited;
    got_q.delete();
    rnd_rdy = 1'b1;
    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(1, 20);
      for (int b = 0; b < len; b++) begin
        mode = 2'($urandom_range(0, 3));
        sd.push_back(8'($urandom));
        sm.push_back(mode);
        sl.push_back(b == len - 1);
        send_beat(sd[sd.size()-1], b == len - 1);
        idle($urandom_range(0, 2));
      end
    end
    rnd_rdy = 1'b0;
    bus.out_ready = 1'b1;
    fm = 2'b00;
    for (int i = 0; i < sd.size(); i++) begin
      if (fr.size() == 0) fm = sm[i];
      fr.push_back(sd[i]);
      if (sl[i] || fr.size() == MAX_LEN) begin
        e.cs  = model_cs(fm, fr);
        e.len = CW'(fr.size());
        e.err = !sl[i];
        exp_q.push_back(e);
        fr.delete();
      end
    end
    waited = 0;
    while (got_q.size() < exp_q.size() && waited < 20) begin
      idle(1);
      waited++;
    end
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rnd_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      g = got_q[i];
      e = exp_q[i];
      n_cmp++; if (g !== e) begin n_fail++; $display("FAIL rnd_frame[%0d]: got cs=%h len=%0d err=%b want cs=%h len=%0d err=%b", i, g.cs, g.len, g.err, e.cs, e.len, e.err); end
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    test_reset();
    test_modes();
    test_max_len();
    test_backpressure();
    test_back_to_back();
    test_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
